// File: rtl/mvu_pkg.sv
// Shared definitions for the bit-serial datapath: default word width,
// precision-field width helper and the serializer shift-stage state type.
package mvu_pkg;

  localparam int unsigned WORD_W = 16;

  // Width needed to hold a precision value in the range 0..w.
  function automatic int unsigned prec_width(input int unsigned w);
    return $clog2(w + 1);
  endfunction

  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_SHIFT = 1'b1
  } shift_state_e;

endpackage

// File: rtl/word_serializer_if.sv
// Word-in / bit-out handshake bundle of the word serializer.
interface word_serializer_if
  import mvu_pkg::*;
#(
  parameter int unsigned W = WORD_W
) ();

  localparam int unsigned PW = prec_width(W);

  logic          in_valid;
  logic          in_ready;
  logic [W-1:0]  in_data;
  logic [PW-1:0] in_prec;
  logic          out_valid;
  logic          out_ready;
  logic          out_bit;
  logic          out_first;
  logic          out_last;

  // Serializer side
  modport slave (
    input  in_valid, in_data, in_prec, out_ready,
    output in_ready, out_valid, out_bit, out_first, out_last
  );

  // Word producer / bit consumer side
  modport master (
    output in_valid, in_data, in_prec, out_ready,
    input  in_ready, out_valid, out_bit, out_first, out_last
  );

endinterface

// File: rtl/word_serializer_hold.sv
// One-entry word buffer holding {prec, data} between the input handshake
// and the shift stage.
module word_hold_reg #(
  parameter int unsigned W  = 16,
  parameter int unsigned PW = 5
) (
  input  logic          clk,
  input  logic          clr,
  input  logic          push,
  input  logic          pop,
  input  logic [W-1:0]  push_data,
  input  logic [PW-1:0] push_prec,
  output logic          full,
  output logic [W-1:0]  data,
  output logic [PW-1:0] prec
);

  logic          full_q, full_d;
  logic [W-1:0]  data_q, data_d;
  logic [PW-1:0] prec_q, prec_d;

  // push only happens when empty and pop only when full, so they never collide
  always_comb begin
    full_d = full_q;
    data_d = data_q;
    prec_d = prec_q;
    if (push) begin
      full_d = 1'b1;
      data_d = push_data;
      prec_d = push_prec;
    end else if (pop) begin
      full_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      full_q <= 1'b0;
      data_q <= '0;
      prec_q <= '0;
    end else begin
      full_q <= full_d;
      data_q <= data_d;
      prec_q <= prec_d;
    end
  end

  assign full = full_q;
  assign data = data_q;
  assign prec = prec_q;

endmodule

// File: rtl/word_serializer.sv
// Parallel-to-serial front end: buffers one word and shifts it out MSB of
// the precision field first, one bit per fired out_valid/out_ready cycle.
module word_serializer
  import mvu_pkg::*;
#(
  parameter int unsigned W = WORD_W
) (
  input  logic               clk,
  input  logic               clr,
  word_serializer_if.slave   bus,
  output logic               busy
);

  localparam int unsigned PW = prec_width(W);

  logic          hold_full;
  logic [W-1:0]  hold_data;
  logic [PW-1:0] hold_prec;
  logic [PW-1:0] prec_in;
  logic          push, xfer, fire, shift_last, shift_full;
  logic [W-1:0]  shifted;

  shift_state_e  st_q, st_d;
  logic [W-1:0]  word_q, word_d;
  logic [PW-1:0] prec_q, prec_d;
  logic [PW-1:0] idx_q, idx_d;

  // Out-of-range precision is treated as full width
  assign prec_in = (bus.in_prec == '0 || bus.in_prec > PW'(W)) ? PW'(W) : bus.in_prec;

  assign bus.in_ready = !hold_full && !clr;
  assign push         = bus.in_valid && bus.in_ready;
  assign shift_full   = (st_q == ST_SHIFT);
  assign shift_last   = (idx_q == '0);
  assign fire         = shift_full && bus.out_ready;
  assign xfer         = hold_full && (!shift_full || (fire && shift_last));

  word_hold_reg #(.W(W), .PW(PW)) u_hold (
    .clk       (clk),
    .clr       (clr),
    .push      (push),
    .pop       (xfer),
    .push_data (bus.in_data),
    .push_prec (prec_in),
    .full      (hold_full),
    .data      (hold_data),
    .prec      (hold_prec)
  );

  always_comb begin
    st_d   = st_q;
    word_d = word_q;
    prec_d = prec_q;
    idx_d  = idx_q;
    if (xfer) begin
      st_d   = ST_SHIFT;
      word_d = hold_data;
      prec_d = hold_prec;
      idx_d  = hold_prec - PW'(1);
    end else if (fire) begin
      if (shift_last) st_d  = ST_EMPTY;
      else            idx_d = idx_q - PW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      st_q   <= ST_EMPTY;
      word_q <= '0;
      prec_q <= '0;
      idx_q  <= '0;
    end else begin
      st_q   <= st_d;
      word_q <= word_d;
      prec_q <= prec_d;
      idx_q  <= idx_d;
    end
  end

  // Outputs decode straight from the shift-stage flops; zero while empty
  assign shifted       = word_q >> idx_q;
  assign bus.out_valid = shift_full;
  assign bus.out_bit   = shift_full && shifted[0];
  assign bus.out_first = shift_full && (idx_q == prec_q - PW'(1));
  assign bus.out_last  = shift_full && shift_last;
  assign busy          = hold_full || shift_full;

endmodule

// File: tb/tb_word_serializer.sv
// Table-driven bench for word_serializer: one record per clock cycle with
// inputs and expected {in_ready, out_valid, out_bit, out_first, out_last, busy}.
module tb_word_serializer;

  localparam int unsigned W = 16;

  typedef struct {
    logic        clr;
    logic        iv;
    logic [15:0] data;
    logic [4:0]  prec;
    logic        ordy;
    logic [5:0]  exp;
  } vec_t;

  logic clk;
  logic clr;
  logic busy;
  int   n_vec;
  int   n_err;
  vec_t vq[$];

  word_serializer_if #(.W(W)) bus ();

  word_serializer #(.W(W)) dut (
    .clk  (clk),
    .clr  (clr),
    .bus  (bus),
    .busy (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic add(input logic c, input logic iv, input logic [15:0] d,
                     input logic [4:0] p, input logic ordy, input logic [5:0] e);
    vec_t v;
    v.clr = c; v.iv = iv; v.data = d; v.prec = p; v.ordy = ordy; v.exp = e;
    vq.push_back(v);
  endtask

  function automatic logic [5:0] observed();
    return {bus.in_ready, bus.out_valid, bus.out_bit, bus.out_first, bus.out_last, busy};
  endfunction

  initial begin
    logic [15:0] rnd_word;
    logic [15:0] got_word;
    int          nbits;
    logic        done;
    logic        first_ok;

    n_vec = 0;
    n_err = 0;

    // Reset: clr held with in_valid asserted
    add(1, 1, 16'hA5C3, 8, 1, 6'b000000);
    add(0, 0, 16'h0000, 0, 1, 6'b100000);
    // Single word 0xA5C3 / prec 8 -> 1,1,0,0,0,0,1,1
    add(0, 1, 16'hA5C3, 8, 1, 6'b100000);
    add(0, 0, 16'h0000, 0, 1, 6'b000001);
    add(0, 0, 16'h0000, 0, 1, 6'b111101);
    add(0, 0, 16'h0000, 0, 1, 6'b111001);
    add(0, 0, 16'h0000, 0, 1, 6'b110001);
    add(0, 0, 16'h0000, 0, 1, 6'b110001);
    add(0, 0, 16'h0000, 0, 1, 6'b110001);
    add(0, 0, 16'h0000, 0, 1, 6'b110001);
    add(0, 0, 16'h0000, 0, 1, 6'b111001);
    add(0, 0, 16'h0000, 0, 1, 6'b111011);
    // Back-to-back 0x000F/4 then 0x0005/3 -> 1111 101 without gap
    add(0, 1, 16'h000F, 4, 1, 6'b100000);
    add(0, 1, 16'h0005, 3, 1, 6'b000001);
    add(0, 1, 16'h0005, 3, 1, 6'b111101);
    add(0, 0, 16'h0000, 0, 1, 6'b011001);
    add(0, 0, 16'h0000, 0, 1, 6'b011001);
    add(0, 0, 16'h0000, 0, 1, 6'b011011);
    add(0, 0, 16'h0000, 0, 1, 6'b111101);
    add(0, 0, 16'h0000, 0, 1, 6'b110001);
    add(0, 0, 16'h0000, 0, 1, 6'b111011);
    // Stall: 1010 / prec 4, out_ready low for 3 cycles on bit 2
    add(0, 1, 16'h000A, 4, 1, 6'b100000);
    add(0, 0, 16'h0000, 0, 1, 6'b000001);
    add(0, 0, 16'h0000, 0, 1, 6'b111101);
    add(0, 0, 16'h0000, 0, 0, 6'b110001);
    add(0, 0, 16'h0000, 0, 0, 6'b110001);
    add(0, 0, 16'h0000, 0, 0, 6'b110001);
    add(0, 0, 16'h0000, 0, 1, 6'b110001);
    add(0, 0, 16'h0000, 0, 1, 6'b111001);
    add(0, 0, 16'h0000, 0, 1, 6'b110011);
    // prec 1 stream: four words, one every 2 cycles
    add(0, 1, 16'h0001, 1, 1, 6'b100000);
    add(0, 1, 16'h0001, 1, 1, 6'b000001);
    add(0, 1, 16'h0001, 1, 1, 6'b111111);
    add(0, 1, 16'h0001, 1, 1, 6'b000001);
    add(0, 1, 16'h0001, 1, 1, 6'b111111);
    add(0, 1, 16'h0001, 1, 1, 6'b000001);
    add(0, 1, 16'h0001, 1, 1, 6'b111111);
    add(0, 0, 16'h0000, 0, 1, 6'b000001);
    add(0, 0, 16'h0000, 0, 1, 6'b111111);
    // prec 0 clamps to 16: 0x8001 -> 1, fourteen 0s, 1
    add(0, 1, 16'h8001, 0, 1, 6'b100000);
    add(0, 0, 16'h0000, 0, 1, 6'b000001);
    add(0, 0, 16'h0000, 0, 1, 6'b111101);
    for (int k = 0; k < 14; k++) add(0, 0, 16'h0000, 0, 1, 6'b110001);
    add(0, 0, 16'h0000, 0, 1, 6'b111011);
    // clr mid-word with HOLD full, then a fresh word
    add(0, 1, 16'h00F0, 8, 1, 6'b100000);
    add(0, 1, 16'h00FF, 8, 1, 6'b000001);
    add(0, 1, 16'h00FF, 8, 1, 6'b111101);
    add(0, 0, 16'h0000, 0, 1, 6'b011001);
    add(0, 0, 16'h0000, 0, 1, 6'b011001);
    add(1, 0, 16'h0000, 0, 1, 6'b011001);
    add(0, 0, 16'h0000, 0, 1, 6'b100000);
    add(0, 1, 16'h0003, 2, 1, 6'b100000);
    add(0, 0, 16'h0000, 0, 1, 6'b000001);
    add(0, 0, 16'h0000, 0, 1, 6'b111101);
    add(0, 0, 16'h0000, 0, 1, 6'b111011);
    add(0, 0, 16'h0000, 0, 1, 6'b100000);

    // First clr cycle, before any edge: only in_ready is defined
    clr           = 1'b1;
    bus.in_valid  = 1'b1;
    bus.in_data   = 16'hA5C3;
    bus.in_prec   = 5'd8;
    bus.out_ready = 1'b1;
    #1;
    n_vec++;
    if (bus.in_ready !== 1'b0) begin
      n_err++;
      $display("FAIL reset_in_ready got %b expected 0", bus.in_ready);
    end

    foreach (vq[i]) begin
      @(negedge clk);
      clr           = vq[i].clr;
      bus.in_valid  = vq[i].iv;
      bus.in_data   = vq[i].data;
      bus.in_prec   = vq[i].prec;
      bus.out_ready = vq[i].ordy;
      #1;
      n_vec++;
      if (observed() !== vq[i].exp) begin
        n_err++;
        $display("FAIL vec%0d {ir,ov,bit,first,last,busy} got %b expected %b",
                 i, observed(), vq[i].exp);
      end
    end

    // Full-width random word, collected until out_last within a cycle budget
    rnd_word = 16'($urandom);
    got_word = '0;
    nbits    = 0;
    done     = 1'b0;
    first_ok = 1'b0;
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.in_data  = rnd_word;
    bus.in_prec  = 5'd16;
    @(negedge clk);
    bus.in_valid = 1'b0;
    for (int c = 0; c < 40 && !done; c++) begin
      #1;
      if (bus.out_valid) begin
        if (nbits == 0) first_ok = bus.out_first;
        got_word = {got_word[14:0], bus.out_bit};
        nbits++;
        if (bus.out_last) done = 1'b1;
      end
      @(negedge clk);
    end
    n_vec++;
    if (!done || nbits != 16 || !first_ok) begin
      n_err++;
      $display("FAIL rand_word_framing got done=%b bits=%0d first=%b expected done=1 bits=16 first=1",
               done, nbits, first_ok);
    end
    n_vec++;
    if (got_word !== rnd_word) begin
      n_err++;
      $display("FAIL rand_word_data got %h expected %h", got_word, rnd_word);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
